// File: rtl/wdt_rst_req_if.sv
// rtl/wdt_rst_req_if.sv - control and status bundle of the watchdog reset-request source
interface wdt_rst_req_if;
    logic       en_i;
    logic       kick_i;
    logic       sw_rst_req_i;
    logic       clear_cause_i;
    logic       rst_req_no;
    logic       warn_o;
    logic [1:0] cause_o;
    logic       busy_o;

    modport master (
        output en_i,
        output kick_i,
        output sw_rst_req_i,
        output clear_cause_i,
        input  rst_req_no,
        input  warn_o,
        input  cause_o,
        input  busy_o
    );

    modport slave (
        input  en_i,
        input  kick_i,
        input  sw_rst_req_i,
        input  clear_cause_i,
        output rst_req_no,
        output warn_o,
        output cause_o,
        output busy_o
    );
endinterface

// File: rtl/wdt_rst_req.sv
// rtl/wdt_rst_req.sv - watchdog and software reset-request pulse source with cause record
module wdt_rst_req #(
    parameter int TimeoutCycles  = 1024,
    parameter int WarnCycles     = 64,
    parameter int ReqPulseCycles = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    wdt_rst_req_if.slave  bus
);

    localparam int MaxCycles = (TimeoutCycles > ReqPulseCycles) ? TimeoutCycles : ReqPulseCycles;
    localparam int CW        = $clog2(MaxCycles + 1);

    localparam logic [CW-1:0] TimeoutLast = CW'(TimeoutCycles - 1);
    localparam logic [CW-1:0] WarnAt      = CW'(TimeoutCycles - WarnCycles);
    localparam logic [CW-1:0] PulseLast   = CW'(ReqPulseCycles - 1);

    localparam logic [1:0] CauseNone = 2'b00;
    localparam logic [1:0] CauseWdt  = 2'b01;
    localparam logic [1:0] CauseSw   = 2'b10;

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("TimeoutCycles must be >= 2");
    end
    if (WarnCycles < 1 || WarnCycles > TimeoutCycles - 1) begin : g_bad_warn
        $error("WarnCycles must be in 1..TimeoutCycles-1");
    end
    if (ReqPulseCycles < 1) begin : g_bad_pulse
        $error("ReqPulseCycles must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_REQ  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    cause_q, cause_d;
    logic          rst_req_nq;
    logic          warn_q;
    logic          busy_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cause_q    <= CauseNone;
            rst_req_nq <= 1'b1;
            warn_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cause_q    <= cause_d;
            // Outputs are flopped from the next-state values so they line up with state_q.
            rst_req_nq <= (state_d != ST_REQ);
            warn_q     <= (state_d == ST_RUN) && (cnt_d >= WarnAt);
            busy_q     <= (state_d == ST_REQ);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = bus.clear_cause_i ? CauseNone : cause_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (bus.sw_rst_req_i) begin
                    state_d = ST_REQ;
                    cause_d = CauseSw;
                end else if (bus.en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Software request outranks disarm, kick and timeout.
                if (bus.sw_rst_req_i) begin
                    state_d = ST_REQ;
                    cause_d = CauseSw;
                    cnt_d   = '0;
                end else if (!bus.en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (bus.kick_i) begin
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = ST_REQ;
                    cause_d = CauseWdt;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            ST_REQ: begin
                if (cnt_q == PulseLast) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.rst_req_no = rst_req_nq;
    assign bus.warn_o     = warn_q;
    assign bus.cause_o    = cause_q;
    assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_wdt_rst_req.sv
// tb/tb_wdt_rst_req.sv - scoreboard bench for wdt_rst_req with directed vectors
module tb_wdt_rst_req;

    typedef struct {
        string      name;
        logic [4:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    wdt_rst_req_if bus ();

    wdt_rst_req #(
        .TimeoutCycles  (8),
        .WarnCycles     (2),
        .ReqPulseCycles (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected tuple after the edge: {rst_req_no, warn_o, cause_o[1:0], busy_o}.
    task automatic step(input string name, input logic en, input logic kick, input logic sw,
                        input logic clr, input logic rq, input logic warn, input logic [1:0] cause,
                        input logic busy);
        exp_t e;
        bus.en_i          = en;
        bus.kick_i        = kick;
        bus.sw_rst_req_i  = sw;
        bus.clear_cause_i = clr;
        @(posedge clk);
        e.name = name;
        e.v    = {rq, warn, cause, busy};
        exp_q.push_back(e);
        #2;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {bus.rst_req_no, bus.warn_o, bus.cause_o, bus.busy_o};
                n_checks++;
                if (act !== e.v) begin
                    n_errors++;
                    $display("FAIL %s: got rq/warn/cause/busy=%b, expected %b", e.name, act, e.v);
                end
            end
        end
    end

    initial begin : stimulus
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.en_i = 1'b0; bus.kick_i = 1'b0; bus.sw_rst_req_i = 1'b0; bus.clear_cause_i = 1'b0;

        step("reset", 0,0,0,0, 1,0,2'd0,0);
        step("reset", 1,1,1,1, 1,0,2'd0,0);
        rst_n = 1'b1;
        step("idle", 0,0,0,0, 1,0,2'd0,0);

        // Timeout with no kick.
        for (int k = 1; k <= 8; k++) step("to_run", 1,0,0,0, 1, (k >= 7), 2'd0, 0);
        for (int k = 9; k <= 12; k++) step("to_pulse", 1,0,0,0, 0,0,2'd1,1);
        step("to_end", 0,0,0,0, 1,0,2'd1,0);
        step("clear_cause", 0,0,0,1, 1,0,2'd0,0);

        // Regular kicks keep the watchdog quiet.
        step("kick_entry", 1,0,0,0, 1,0,2'd0,0);
        for (int i = 0; i < 100; i++) step("kick_run", 1, (i % 5 == 4), 0,0, 1,0,2'd0,0);
        step("kick_exit", 0,0,0,0, 1,0,2'd0,0);

        // Kick coinciding with the timeout cycle.
        step("kto_entry", 1,0,0,0, 1,0,2'd0,0);
        for (int j = 1; j <= 7; j++) step("kto_run", 1,0,0,0, 1, (j >= 6), 2'd0, 0);
        step("kto_kick", 1,1,0,0, 1,0,2'd0,0);
        step("kto_after", 1,0,0,0, 1,0,2'd0,0);
        step("kto_exit", 0,0,0,0, 1,0,2'd0,0);

        // Software request from IDLE; requests during the pulse are ignored.
        step("sw_idle", 0,0,1,0, 0,0,2'd2,1);
        for (int j = 0; j < 3; j++) step("sw_idle_pulse", 1,1,1,0, 0,0,2'd2,1);
        step("sw_idle_end", 0,0,0,0, 1,0,2'd2,0);

        // Software request with kick at cnt=7.
        step("sw_run_entry", 1,0,0,0, 1,0,2'd2,0);
        for (int j = 1; j <= 7; j++) step("sw_run", 1,0,0,0, 1, (j >= 6), 2'd2, 0);
        step("sw_run_req", 1,1,1,0, 0,0,2'd2,1);
        for (int j = 0; j < 3; j++) step("sw_run_pulse", 1,0,1,0, 0,0,2'd2,1);
        step("sw_run_end", 0,0,0,0, 1,0,2'd2,0);

        // Disarm at cnt=7, then re-arm restarts from zero.
        step("dis_clear", 0,0,0,1, 1,0,2'd0,0);
        step("dis_entry", 1,0,0,0, 1,0,2'd0,0);
        for (int j = 1; j <= 7; j++) step("dis_run", 1,0,0,0, 1, (j >= 6), 2'd0, 0);
        step("dis_drop", 0,0,0,0, 1,0,2'd0,0);
        step("dis_rearm", 1,0,0,0, 1,0,2'd0,0);
        for (int j = 1; j <= 6; j++) step("dis_restart", 1,0,0,0, 1, (j >= 6), 2'd0, 0);
        step("dis_exit", 0,0,0,0, 1,0,2'd0,0);

        // Board reset in the second REQ cycle.
        step("mid_req", 0,0,1,0, 0,0,2'd2,1);
        step("mid_req2", 0,0,0,0, 0,0,2'd2,1);
        rst_n = 1'b0;
        step("mid_reset", 0,0,0,0, 1,0,2'd0,0);
        rst_n = 1'b1;

        // Clear together with a timeout: new cause wins.
        step("clr_to_entry", 1,0,0,0, 1,0,2'd0,0);
        for (int j = 1; j <= 7; j++) step("clr_to_run", 1,0,0,0, 1, (j >= 6), 2'd0, 0);
        step("clr_to_req", 1,0,0,1, 0,0,2'd1,1);
        for (int j = 0; j < 3; j++) step("clr_to_pulse", 1,0,0,0, 0,0,2'd1,1);
        step("clr_to_end", 0,0,0,0, 1,0,2'd1,0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
